// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: MEM/WB pipeline packet shared by the original/duplicate pipelines and QED logic.
package mem_wb_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } MEM_WB_PACKET;
endpackage

// File: rtl/qed_trace_pkg.sv
// qed_trace_pkg: shared types and defaults for the multi-channel QED trace capture.
// The entry carries a cycle stamp only when QED_TRACE_TIMESTAMP_EN is defined.
package qed_trace_pkg;
  import mem_wb_pkg::*;
  typedef enum logic [1:0] {ARMED = 2'd0, POST = 2'd1, FROZEN = 2'd2} QED_TRACE_STATE;
  localparam int DEPTH_DEF     = 16;
  localparam int POST_TRIG_DEF = 4;
  localparam int STAMP_W       = 32;
  typedef struct packed {
    MEM_WB_PACKET pkt;
`ifdef QED_TRACE_TIMESTAMP_EN
    logic [STAMP_W-1:0] stamp;
`endif
  } qed_trace_entry_t;
endpackage

// File: rtl/qed_trace_ring.sv
// qed_trace_ring: one channel's circular trace buffer with an oldest-relative read port.
module qed_trace_ring
  import qed_trace_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             we,
  input  qed_trace_entry_t wdata,
  input  logic [AW-1:0]    rd_idx,
  output logic [CW-1:0]    count,
  output logic             rd_oob,
  output qed_trace_entry_t rd_data
);
  logic [AW-1:0] head_q, head_d;
  logic [CW-1:0] count_q, count_d;
  qed_trace_entry_t mem_q [DEPTH];
  always_comb begin
    head_d  = clr ? '0 : we ? head_q + AW'(1) : head_q;
    count_d = clr ? '0 : (we && count_q != CW'(DEPTH)) ? count_q + CW'(1) : count_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      count_q <= count_d;
    end
  end
  // storage is not reset, so the write is gated by reset explicitly
  always_ff @(posedge clk) begin
    if (we && !clr && reset) mem_q[head_q] <= wdata;
  end
  assign count   = count_q;
  assign rd_oob  = {1'b0, rd_idx} >= count_q;
  assign rd_data = mem_q[head_q - count_q[AW-1:0] + rd_idx];
endmodule

// File: rtl/qed_trace_mc.sv
// qed_trace_mc: multi-channel MEM/WB trace capture with post-trigger window and indexed readout.
// Define QED_TRACE_TIMESTAMP_EN to store a cycle stamp per entry and expose rd_stamp.
module qed_trace_mc
  import mem_wb_pkg::*;
  import qed_trace_pkg::*;
#(
  parameter  int NUM_CH    = 2,
  parameter  int DEPTH     = DEPTH_DEF,
  parameter  int POST_TRIG = POST_TRIG_DEF,
  parameter  int CNT_W     = 32,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = AW + 1,
  localparam int CH_W      = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  MEM_WB_PACKET [NUM_CH-1:0]      pkt_in,
  input  logic                           fault,
  input  logic                           rearm,
  input  logic                           rd_en,
  input  logic [CH_W-1:0]                rd_ch,
  input  logic [AW-1:0]                  rd_idx,
  output logic                           rd_valid,
  output logic                           rd_oob,
  output MEM_WB_PACKET                   rd_data,
  output logic [1:0]                     state_out,
  output logic [NUM_CH-1:0][CW-1:0]      count_out,
`ifdef QED_TRACE_TIMESTAMP_EN
  output logic [CNT_W-1:0]               rd_stamp,
`endif
  output logic [CNT_W-1:0]               trig_cycle
);
  localparam int NSEL    = 2 ** CH_W;
  localparam int PT_LAST = POST_TRIG > 0 ? POST_TRIG - 1 : 0;
  QED_TRACE_STATE   state_q, state_d;
  logic [AW-1:0]    post_q, post_d;
  logic [CNT_W-1:0] trig_q, trig_d;
  logic             rd_valid_q, rd_valid_d, rd_oob_q, rd_oob_d;
  qed_trace_entry_t rd_ent_q, rd_ent_d;
  logic             cap;
  logic             oob_s [NSEL];
  qed_trace_entry_t ent_s [NSEL];
`ifdef QED_TRACE_TIMESTAMP_EN
  logic [CNT_W-1:0] cyc_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cyc_q <= '0;
    else cyc_q <= cyc_q + CNT_W'(1);
  end
  assign rd_stamp = CNT_W'(rd_ent_q.stamp);
`endif
  assign cap = state_q != FROZEN && !rearm;
  // unused select slots read as out-of-bounds so a bad rd_ch returns zero data
  for (genvar c = 0; c < NSEL; c++) begin : g_ch
    if (c < NUM_CH) begin : g_ring
      qed_trace_entry_t wr;
      always_comb begin
        wr     = '0;
        wr.pkt = pkt_in[c];
`ifdef QED_TRACE_TIMESTAMP_EN
        wr.stamp = STAMP_W'(cyc_q);
`endif
      end
      qed_trace_ring #(.DEPTH(DEPTH)) u_ring (
        .clk     (clk),
        .reset   (reset),
        .clr     (rearm),
        .we      (cap && pkt_in[c].valid),
        .wdata   (wr),
        .rd_idx  (rd_idx),
        .count   (count_out[c]),
        .rd_oob  (oob_s[c]),
        .rd_data (ent_s[c])
      );
    end else begin : g_pad
      assign oob_s[c] = 1'b1;
      assign ent_s[c] = '0;
    end
  end
  always_comb begin
    state_d = rearm ? ARMED
            : (state_q == ARMED && fault) ? (POST_TRIG == 0 ? FROZEN : POST)
            : (state_q == POST && post_q == AW'(PT_LAST)) ? FROZEN : state_q;
    post_d     = rearm ? '0 : state_q == POST ? post_q + AW'(1) : post_q;
    trig_d     = rearm ? '0 : (state_q == ARMED && !fault && !(&trig_q)) ? trig_q + CNT_W'(1) : trig_q;
    rd_valid_d = rd_en && state_q == FROZEN;
    rd_oob_d   = rd_valid_d && oob_s[rd_ch];
    rd_ent_d   = (rd_valid_d && !oob_s[rd_ch]) ? ent_s[rd_ch] : '0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ARMED;
      post_q     <= '0;
      trig_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_oob_q   <= 1'b0;
      rd_ent_q   <= '0;
    end else begin
      state_q    <= state_d;
      post_q     <= post_d;
      trig_q     <= trig_d;
      rd_valid_q <= rd_valid_d;
      rd_oob_q   <= rd_oob_d;
      rd_ent_q   <= rd_ent_d;
    end
  end
  assign state_out  = state_q;
  assign trig_cycle = trig_q;
  assign rd_valid   = rd_valid_q;
  assign rd_oob     = rd_oob_q;
  assign rd_data    = rd_ent_q.pkt;
endmodule

// File: tb/tb_qed_trace_mc.sv
// tb_qed_trace_mc: directed and random checks of two trace instances (POST_TRIG=4 and POST_TRIG=0)
// against a queue-based reference model.
module tb_qed_trace_mc;
  import mem_wb_pkg::*;
  import qed_trace_pkg::*;
  localparam int DEP = 16;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  MEM_WB_PACKET [1:0] pkt;
  logic fault4, fault0, rearm, rd_en, rd_ch;
  logic [3:0] rd_idx;
  logic rdv [2];
  logic rdo [2];
  MEM_WB_PACKET rdd [2];
  logic [1:0] st [2];
  logic [1:0][4:0] cnt [2];
  logic [31:0] trig [2];
`ifdef QED_TRACE_TIMESTAMP_EN
  logic [31:0] stp [2];
`endif
  qed_trace_mc #(.NUM_CH(2), .DEPTH(DEP), .POST_TRIG(4), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .pkt_in(pkt), .fault(fault4), .rearm(rearm),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_idx(rd_idx), .rd_valid(rdv[0]), .rd_oob(rdo[0]),
    .rd_data(rdd[0]), .state_out(st[0]), .count_out(cnt[0]),
`ifdef QED_TRACE_TIMESTAMP_EN
    .rd_stamp(stp[0]),
`endif
    .trig_cycle(trig[0])
  );
  qed_trace_mc #(.NUM_CH(2), .DEPTH(DEP), .POST_TRIG(0), .CNT_W(32)) u_dut0 (
    .clk(clk), .reset(reset), .pkt_in(pkt), .fault(fault0), .rearm(rearm),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_idx(rd_idx), .rd_valid(rdv[1]), .rd_oob(rdo[1]),
    .rd_data(rdd[1]), .state_out(st[1]), .count_out(cnt[1]),
`ifdef QED_TRACE_TIMESTAMP_EN
    .rd_stamp(stp[1]),
`endif
    .trig_cycle(trig[1])
  );
  int checks = 0;
  int errors = 0;
  MEM_WB_PACKET mq [2][2][$];
  int mst [2];
  int mtrig [2];
  int mcyc [2];
  int mleft [2];
  logic erv [2];
  logic ero [2];
  MEM_WB_PACKET erd [2];
  MEM_WB_PACKET sent [$];
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic MEM_WB_PACKET rp();
    MEM_WB_PACKET p;
    p       = '0;
    p.valid = 1'b1;
    p.pc    = $urandom;
    p.rd    = 5'($urandom);
    p.wdata = $urandom;
    return p;
  endfunction
  task automatic mreset();
    for (int m = 0; m < 2; m++) begin
      mst[m] = 0; mtrig[m] = 0; mcyc[m] = 0; mleft[m] = 0;
      erv[m] = 1'b0; ero[m] = 1'b0; erd[m] = '0;
      for (int c = 0; c < 2; c++) mq[m][c].delete();
    end
  endtask
  // one clock of the reference: m selects the instance, pt its post-trigger length
  task automatic step(input int m, input int pt, input logic f);
    if (rearm) begin
      mst[m] = 0; mtrig[m] = 0; mcyc[m] = 0;
      for (int c = 0; c < 2; c++) mq[m][c].delete();
      return;
    end
    if (mst[m] != 2)
      for (int c = 0; c < 2; c++)
        if (pkt[c].valid) begin
          mq[m][c].push_back(pkt[c]);
          if (mq[m][c].size() > DEP) void'(mq[m][c].pop_front());
        end
    if (mst[m] == 0) begin
      if (f) begin
        mtrig[m] = mcyc[m];
        mleft[m] = pt;
        mst[m]   = pt == 0 ? 2 : 1;
      end else mcyc[m]++;
    end else if (mst[m] == 1) begin
      mleft[m]--;
      if (mleft[m] == 0) mst[m] = 2;
    end
  endtask
  task automatic cmp();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("state%0d", m), 128'(st[m]), 128'(mst[m]));
      chk($sformatf("trig%0d", m), 128'(trig[m]), 128'(mst[m] == 0 ? mcyc[m] : mtrig[m]));
      for (int c = 0; c < 2; c++)
        chk($sformatf("count%0d_ch%0d", m, c), 128'(cnt[m][c]), 128'(mq[m][c].size()));
      chk($sformatf("rd_valid%0d", m), 128'(rdv[m]), 128'(erv[m]));
      chk($sformatf("rd_oob%0d", m), 128'(rdo[m]), 128'(ero[m]));
      chk($sformatf("rd_data%0d", m), 128'(rdd[m]), 128'(erd[m]));
    end
  endtask
  task automatic tick();
    for (int m = 0; m < 2; m++) begin
      erv[m] = rd_en && mst[m] == 2;
      ero[m] = erv[m] && int'(rd_idx) >= mq[m][rd_ch].size();
      erd[m] = '0;
      if (erv[m] && !ero[m]) erd[m] = mq[m][rd_ch][rd_idx];
    end
    step(0, 4, fault4);
    step(1, 0, fault0);
    @(posedge clk);
    #1;
    cmp();
  endtask
  initial begin
    pkt = '0; fault4 = 0; fault0 = 0; rearm = 0; rd_en = 0; rd_ch = 0; rd_idx = '0;
    mreset();
    #12;
    cmp();
    #11 reset = 1'b1;
    // ch0: 5 packets, ch1: 3, then fault cycle and 4 post-trigger cycles
    for (int i = 0; i < 5; i++) begin
      pkt[0] = rp();
      pkt[1] = i < 3 ? rp() : '0;
      sent.push_back(pkt[0]);
      tick();
    end
    fault4 = 1; pkt[0] = rp(); pkt[1] = rp(); sent.push_back(pkt[0]);
    tick();
    fault4 = 0;
    chk("post_entered", 128'(st[0]), 128'(1));
    for (int i = 0; i < 4; i++) begin
      pkt[0] = rp(); pkt[1] = rp(); sent.push_back(pkt[0]);
      tick();
      chk("freeze_timing", 128'(st[0]), 128'(i == 3 ? 2 : 1));
    end
    pkt = '0;
    chk("count_ch0", 128'(cnt[0][0]), 128'(10));
    chk("count_ch1", 128'(cnt[0][1]), 128'(8));
    chk("trig_a", 128'(trig[0]), 128'(5));
    rd_en = 1; rd_ch = 0;
    for (int i = 0; i < 10; i++) begin
      rd_idx = 4'(i);
      tick();
      chk("arrival_order", 128'(rdd[0]), 128'(sent[i]));
      chk("read_armed", 128'(rdv[1]), 128'(0));
    end
    rd_ch = 1; rd_idx = 4'd9;
    tick();
    chk("oob_valid", 128'(rdv[0]), 128'(1));
    chk("oob_flag", 128'(rdo[0]), 128'(1));
    chk("oob_data", 128'(rdd[0]), 128'(0));
    rd_en = 0;
    fault4 = 1;
    tick();
    fault4 = 0;
    chk("frozen_fault_state", 128'(st[0]), 128'(2));
    chk("frozen_fault_trig", 128'(trig[0]), 128'(5));
    // wrap: 20 writes on ch0, fault on the 20th, POST_TRIG=0
    rearm = 1;
    tick();
    rearm = 0;
    sent.delete();
    repeat (18) tick();
    for (int i = 0; i < 20; i++) begin
      pkt[0] = rp(); pkt[1] = '0; sent.push_back(pkt[0]);
      fault0 = i == 19;
      tick();
    end
    fault0 = 0; pkt = '0;
    chk("pt0_frozen", 128'(st[1]), 128'(2));
    chk("trig_37", 128'(trig[1]), 128'(37));
    chk("wrap_count", 128'(cnt[1][0]), 128'(16));
    rd_en = 1; rd_ch = 0; rd_idx = 4'd0;
    tick();
    chk("wrap_oldest", 128'(rdd[1]), 128'(sent[4]));
    rd_idx = 4'd15;
    tick();
    chk("wrap_newest", 128'(rdd[1]), 128'(sent[19]));
    rd_en = 0;
    fault0 = 1;
    tick();
    fault0 = 0;
    chk("trig_37_hold", 128'(trig[1]), 128'(37));
    // fault then fault+rearm in POST
    fault4 = 1;
    tick();
    chk("post_again", 128'(st[0]), 128'(1));
    rearm = 1;
    tick();
    rearm = 0; fault4 = 0;
    chk("rearm_state", 128'(st[0]), 128'(0));
    chk("rearm_count", 128'(cnt[0][0]), 128'(0));
    chk("rearm_trig", 128'(trig[0]), 128'(0));
    rd_en = 1;
    tick();
    chk("armed_rd_valid", 128'(rdv[0]), 128'(0));
    rd_en = 0;
    repeat (300) begin
      for (int c = 0; c < 2; c++) pkt[c] = $urandom_range(0, 3) != 0 ? rp() : '0;
      fault4 = $urandom_range(0, 19) == 0;
      fault0 = $urandom_range(0, 19) == 0;
      rearm  = $urandom_range(0, 39) == 0;
      rd_en  = 1'($urandom_range(0, 1));
      rd_ch  = 1'($urandom_range(0, 1));
      rd_idx = 4'($urandom_range(0, 15));
      tick();
    end
    pkt = '0; fault4 = 0; fault0 = 0; rearm = 0; rd_en = 0;
    // asynchronous reset in the middle of POST
    rearm = 1;
    tick();
    rearm = 0;
    pkt[0] = rp(); pkt[1] = rp(); fault4 = 1;
    tick();
    fault4 = 0;
    tick();
    chk("pre_reset_post", 128'(st[0]), 128'(1));
    #3 reset = 1'b0;
    #1;
    mreset();
    cmp();
    pkt[0] = rp(); pkt[1] = rp();
    @(posedge clk);
    #1;
    cmp();
    #2 reset = 1'b1;
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
